mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the address width of both ports.
REQ-002 SHALL have parameter FETCH_WIDTH, default 64, the dmem data width in bits; legal values are 32 and 64.
REQ-003 SHALL have parameter DEPTH_BYTES, default 65536, the backing-store size in bytes; it is a power of two.
REQ-004 SHALL have parameter LATENCY, default 2, the number of cycles from acceptance to rdy; legal range is 1..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-007 SHALL have ports dmem_rd_en_i, dmem_wr_en_i and imem_rd_en_i, each an input of 1 bit: level request strobes from the core.
REQ-008 SHALL have ports dmem_addr_i and imem_addr_i, each an input of DATA_WIDTH bits: byte addresses.
REQ-009 SHALL have port dmem_wr_size_i, input, clog2(FETCH_WIDTH/8) bits: write byte count minus 1.
REQ-010 SHALL have port dmem_wr_data_i, input, FETCH_WIDTH bits: write data, little-endian, byte 0 at the address.
REQ-011 SHALL have ports dmem_busy_o and imem_busy_o, each an output of 1 bit: the port cannot accept a request.
REQ-012 SHALL have ports dmem_rdy_o and imem_rdy_o, each an output of 1 bit: a one-cycle completion pulse.
REQ-013 SHALL have port dmem_rd_data_o, output, FETCH_WIDTH bits: read data, valid only while dmem_rdy_o=1.
REQ-014 SHALL have port imem_rd_data_o, output, 32 bits: instruction word, valid only while imem_rdy_o=1.

Function
REQ-015 SHALL hold an internal byte array of DEPTH_BYTES entries, single-ported, serving one access at a time.
REQ-016 SHALL implement an FSM with states IDLE, D_RD, D_WR and I_RD.
- IDLE -> D_WR if dmem_wr_en_i=1; else D_RD if dmem_rd_en_i=1; else I_RD if imem_rd_en_i=1.
- Any service state -> IDLE on the cycle its rdy pulse is issued.
REQ-017 SHALL accept a request only in IDLE; acceptance captures address, size and data into internal registers.
REQ-018 SHALL resolve simultaneous requests with priority dmem write > dmem read > imem read; a dmem_rd_en_i=1 together with dmem_wr_en_i=1 is serviced as a write only.
REQ-019 SHALL drive both busy outputs to 1 from the edge after acceptance until the cycle after the rdy pulse.
- This applies to both ports because the store is single-ported.
- dmem_busy_o and imem_busy_o are always equal.
REQ-020 SHALL assert the serviced port's rdy for exactly one cycle, LATENCY cycles after the accepting edge, using a 4-bit down-counter loaded with LATENCY-1.
REQ-021 SHALL require each requester to hold its enable and operands stable until rdy; it SHALL ignore any strobe that is not accepted.
REQ-022 SHALL on D_WR write (dmem_wr_size_i+1) bytes starting at the captured address, and SHALL pulse dmem_rdy_o as an acknowledge with dmem_rd_data_o=0.
REQ-023 SHALL on D_RD return FETCH_WIDTH/8 bytes starting at the address; on I_RD it SHALL return 4 bytes.
REQ-024 SHALL support unaligned accesses with no alignment restriction.
REQ-025 SHALL read any byte at address >= DEPTH_BYTES as 0x00 and SHALL drop writes to it, without wrap-around.
- This holds per byte, so an access that straddles the end is partially served.
REQ-026 SHALL drive rd_data outputs to 0 whenever the matching rdy is 0.
REQ-027 SHALL allow a new request to be accepted on the first IDLE cycle after rdy, giving back-to-back throughput of one access per LATENCY+1 cycles.

Reset
REQ-028 SHALL on rst=0, asynchronously, force the FSM to IDLE, the counter to 0, both rdy to 0, both busy to 0 and both rd_data to 0.
REQ-029 SHALL abandon any in-flight access when reset is asserted mid-operation.
- No rdy is ever issued for it.
- A write not yet committed SHALL NOT modify the array; writes commit on the rdy cycle.
REQ-030 SHALL NOT clear the array contents on reset; a bench preloads them hierarchically.
REQ-031 SHALL sample requests from the first rising edge after rst returns to 1.

Verification
REQ-032 Reset then read: LATENCY=2; dmem_rd_en_i=1, addr 0x10 preloaded 0x1122334455667788 -> busy=1 for 2 cycles, dmem_rdy_o pulses at cycle 2 with 0x1122334455667788.
REQ-033 Sized write: write size 1, data 0xBEEF at 0x21, then an 8-byte read at 0x20 -> bytes 0x21=0xEF and 0x22=0xBE, all other bytes unchanged.
REQ-034 Arbitration: imem_rd_en_i and dmem_rd_en_i raised in the same cycle -> dmem served first; imem_rdy_o follows LATENCY+1 cycles after dmem_rdy_o.
REQ-035 Boundary: 8-byte read at DEPTH_BYTES-2 with the last two bytes 0xAA, 0xBB -> data 0x000000000000BBAA; an 8-byte write at DEPTH_BYTES-2 -> only 2 bytes are written.
REQ-036 Reset mid-write: assert rst=0 one cycle after accepting a write of 0xFF to 0x40 -> no rdy, busy=0, byte 0x40 keeps its old value.
REQ-037 Simultaneous strobes: dmem_rd_en_i=1 and dmem_wr_en_i=1 to 0x80 -> one write and one dmem_rdy_o with data 0; a subsequent read returns the written value.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: behavioural single-ported byte memory that serves a core's
// data port (read/write) and instruction port (read) one access at a time,
// with a fixed access latency.
//
// Ports
//   clk, rst                       clock; asynchronous active-low reset
//   dmem_rd_en_i / dmem_wr_en_i    data-port level strobes
//   dmem_addr_i                    data-port byte address
//   dmem_wr_size_i                 write byte count minus 1
//   dmem_wr_data_i                 write data, little-endian
//   dmem_busy_o / dmem_rdy_o       data port busy / one-cycle completion
//   dmem_rd_data_o                 read data, zero unless dmem_rdy_o
//   imem_rd_en_i / imem_addr_i     instruction-port strobe and address
//   imem_busy_o / imem_rdy_o       instruction port busy / completion
//   imem_rd_data_o                 32-bit instruction word, zero unless imem_rdy_o
//
// State | meaning
// IDLE  | waiting for a request; the only state that accepts one
// D_RD  | serving a data read, counting down to the rdy cycle
// D_WR  | serving a data write; bytes commit at the end of the rdy cycle
// I_RD  | serving an instruction fetch
module mem_responder #(
    parameter int DATA_WIDTH  = 64,
    parameter int FETCH_WIDTH = 64,
    parameter int DEPTH_BYTES = 65536,
    parameter int LATENCY     = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               dmem_rd_en_i,
    input  logic                               dmem_wr_en_i,
    input  logic                               imem_rd_en_i,
    input  logic [DATA_WIDTH-1:0]              dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]              imem_addr_i,
    input  logic [$clog2(FETCH_WIDTH/8)-1:0]   dmem_wr_size_i,
    input  logic [FETCH_WIDTH-1:0]             dmem_wr_data_i,
    output logic                               dmem_busy_o,
    output logic                               imem_busy_o,
    output logic                               dmem_rdy_o,
    output logic                               imem_rdy_o,
    output logic [FETCH_WIDTH-1:0]             dmem_rd_data_o,
    output logic [31:0]                        imem_rd_data_o
);

    localparam int FETCH_BYTES = FETCH_WIDTH / 8;
    localparam int SIZE_W      = $clog2(FETCH_BYTES);
    localparam int MEM_AW      = $clog2(DEPTH_BYTES);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, D_RD, D_WR, I_RD} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q;
    logic [DATA_WIDTH-1:0]  addr_q;
    logic [SIZE_W-1:0]      size_q;
    logic [FETCH_WIDTH-1:0] wdata_q;
    logic                   accept;
    logic                   done;
    logic [FETCH_WIDTH-1:0] d_word;
    logic [31:0]            i_word;

    logic [7:0] mem [DEPTH_BYTES];

    // Range check is done one bit wider than the address so that an access
    // near the top of the address space cannot wrap back into the array.
    function automatic logic in_range(input logic [DATA_WIDTH-1:0] base, input int off);
        logic [DATA_WIDTH:0] a;
        a = {1'b0, base} + (DATA_WIDTH+1)'(off);
        return a < (DATA_WIDTH+1)'(DEPTH_BYTES);
    endfunction

    function automatic logic [7:0] rd_byte(input logic [DATA_WIDTH-1:0] base, input int off);
        logic [DATA_WIDTH-1:0] a;
        a = base + DATA_WIDTH'(off);
        if (in_range(base, off))
            return mem[a[MEM_AW-1:0]];
        return 8'h00;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q   <= CNT_LOAD;
                addr_q  <= (state_d == I_RD) ? imem_addr_i : dmem_addr_i;
                size_q  <= dmem_wr_size_i;
                wdata_q <= dmem_wr_data_i;
            end else if (state_q != IDLE && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        done           = (state_q != IDLE) && (cnt_q == 4'd0);
        dmem_busy_o    = (state_q != IDLE);
        imem_busy_o    = (state_q != IDLE);
        dmem_rdy_o     = done && (state_q == D_RD || state_q == D_WR);
        imem_rdy_o     = done && (state_q == I_RD);
        dmem_rd_data_o = '0;
        imem_rd_data_o = '0;

        case (state_q)
            IDLE: begin
                if (dmem_wr_en_i) begin
                    state_d = D_WR;
                    accept  = 1'b1;
                end else if (dmem_rd_en_i) begin
                    state_d = D_RD;
                    accept  = 1'b1;
                end else if (imem_rd_en_i) begin
                    state_d = I_RD;
                    accept  = 1'b1;
                end
            end
            default: begin
                if (done)
                    state_d = IDLE;
            end
        endcase

        // A write acknowledge carries zero data, so only D_RD exposes d_word.
        if (done && state_q == D_RD)
            dmem_rd_data_o = d_word;
        if (imem_rdy_o)
            imem_rd_data_o = i_word;
    end

    always_comb begin
        d_word = '0;
        for (int i = 0; i < FETCH_BYTES; i++)
            d_word[8*i +: 8] = rd_byte(addr_q, i);
    end

    always_comb begin
        i_word = '0;
        for (int i = 0; i < 4; i++)
            i_word[8*i +: 8] = rd_byte(addr_q, i);
    end

    // Commit on the edge that closes the rdy cycle; a reset before then leaves
    // the state in IDLE so nothing is written.
    always_ff @(posedge clk) begin
        if (state_q == D_WR && done) begin
            for (int i = 0; i < FETCH_BYTES; i++) begin
                if (i <= int'(size_q) && in_range(addr_q, i))
                    mem[MEM_AW'(addr_q + DATA_WIDTH'(i))] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule
